muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
//  Takes two 32-bit operands and a funct3 op, and computes the result over several cycles.
//  Presents the result as one data input of the writeback/result 4:1 select mux.
//  The pipeline stalls on busy and captures result when done pulses.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk     in   1     single clock, rising edge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     request; accepted only in IDLE
//  flush   in   1     abort the in-flight op (pipeline flush)
//  op      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a       in   XLEN  rs1 operand, sampled on accept
//  b       in   XLEN  rs2 operand, sampled on accept
//  busy    out  1     high whenever state != IDLE
//  done    out  1     one-cycle pulse; result is valid this cycle
//  result  out  XLEN  result; held until the next accepted start
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; busy=0, done=0, result=0; internal regs cleared.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 latches op, a, b and sign flags.
//     Operands are converted to magnitudes per op signedness.
//     MULHSU: a signed, b unsigned. DIVU/REMU/MULHU: both unsigned.
//   Special cases are resolved in IDLE and go straight to DONE, so done comes 1 cycle after accept:
//     div-by-zero (b==0): DIV/DIVU -> all ones; REM/REMU -> a.
//     signed overflow (DIV/REM, a==0x8000_0000, b==0xFFFF_FFFF): DIV -> 0x8000_0000; REM -> 0.
//   CALC: exactly XLEN cycles, driven by a 5-bit down-counter.
//     mul: shift-add into a 2*XLEN product register.
//     div: restoring, 1 quotient bit per cycle; remainder XLEN+1 bits.
//   FIX: 1 cycle. Two's-complement negation applies where the sign rule requires it:
//     product when sign(a) xor sign(b) under signed interpretation;
//     quotient when sign(a) xor sign(b); remainder takes the sign of a.
//     Selects low half (MUL) or high half (MULH*), quotient or remainder.
//     The chosen value is written to result.
//   DONE: done=1 for 1 cycle, then IDLE. busy drops in the same cycle done rises.
//  Latency: accept at edge k -> done high during cycle k+XLEN+2 (34 for XLEN=32).
//  start while busy: ignored, not queued. start in the DONE cycle: also ignored.
//  start and done: in the cycle after DONE (IDLE), a new start is accepted.
//  flush: any non-IDLE state -> IDLE next edge.
//    No done pulse is produced; result keeps its previous value.
//    flush and start together in IDLE: flush wins; nothing is accepted.
//  rst mid-operation: same as the reset values; the op is lost.
//  Arithmetic is all modulo 2^XLEN. No exceptions are raised (RV32M semantics).
// STRUCTURE
//  Shared package/header muldiv_pkg: op encodings MD_MUL..MD_REMU, FSM state
//   constants S_IDLE/S_CALC/S_FIX/S_DONE, XLEN default.
//  Op encodings are shared with the decoder.
//  Flat implementation: one FSM plus a shared datapath.
//   The product and remainder/quotient registers are reused between mul and div.
//   No sub-module is required.
// TESTING
//  1 MUL a=7, b=-3 (0xFFFF_FFFD) -> result 0xFFFF_FFEB; done exactly 34 cycles after accept.
//  2 MULHU a=b=0xFFFF_FFFF -> result 0xFFFF_FFFE.
//    MULH with the same operands -> 0x0000_0000.
//    MULHSU a=-1, b=2 -> 0xFFFF_FFFF.
//  3 Division: DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4 Special cases, each with done 1 cycle after accept:
//    DIV x/0 -> 0xFFFF_FFFF; REM 5/0 -> 5;
//    DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
//  5 Flush at CALC cycle 10 -> busy=0 next cycle; no done; result unchanged.
//    An immediate new op then completes correctly.
//  6 Pulse start during busy and during DONE -> ignored; exactly one done per accepted start.
//    Assert rst mid-CALC -> busy=0, done=0, result=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M funct3 encodings, FSM states and default width for muldiv_unit
package muldiv_pkg;
  localparam int MD_XLEN = 32;
  typedef enum logic [2:0] {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU} md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M mul/div (clk, rst, start, flush, op, a, b -> busy, done, result)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  state_e state, next_state;
  md_op_e op_q;
  logic [XLEN-1:0] opnd, mag_a, mag_b, spec_val, qv, rv, fix_val;
  logic [2*XLEN-1:0] prod, step, pneg;
  logic [XLEN:0] sum, trial, diff;
  logic [CW-1:0] cnt;
  logic neg_res, neg_rem, is_div, sa, sb, div0, ovf, special, accept;
  always_comb begin
    is_div = op[2];
    sa = a[XLEN-1] & !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
    sb = b[XLEN-1] & !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU || op == MD_MULHSU);
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    div0 = is_div && b == '0;
    ovf = (op == MD_DIV || op == MD_REM) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    special = div0 || ovf;
    spec_val = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    accept = state == S_IDLE && start && !flush;
    sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    trial = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    diff = trial - {1'b0, opnd};
    step = op_q[2] ? (diff[XLEN] ? {trial[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1})
                   : {sum, prod[XLEN-1:1]};
    pneg = neg_res ? -prod : prod;
    qv = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rv = neg_rem ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    fix_val = op_q[2] ? (op_q[1] ? rv : qv) : (op_q == MD_MUL ? pneg[XLEN-1:0] : pneg[2*XLEN-1:XLEN]);
    busy = state == S_CALC || state == S_FIX;
    done = state == S_DONE;
  end
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:  next_state = cnt == '0 ? S_FIX : S_CALC;
      S_FIX:   next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : next_state;
  // prod holds {hi, lo} for mul (multiplier shifts out of lo) and {rem, quotient} for div
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= MD_MUL;
      opnd <= '0;
      prod <= '0;
      cnt <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q <= md_op_e'(op);
      opnd <= is_div ? mag_b : mag_a;
      prod <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
      cnt <= '1;
      neg_res <= sa ^ sb;
      neg_rem <= sa;
      if (special) result <= spec_val;
    end else if (state == S_CALC && !flush) begin
      prod <= step;
      cnt <= cnt - 1'b1;
    end else if (state == S_FIX && !flush) begin
      result <= fix_val;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table-driven check of muldiv_unit plus flush/ignore/reset sequences
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst, start, flush, busy, done;
  logic [2:0] op;
  logic [31:0] a, b, result;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .a(a), .b(b),
                   .busy(busy), .done(done), .result(result));
  typedef struct {md_op_e op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat;} vec_t;
  vec_t vecs[20];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(o, x, y);
    wait_done(lat);
    check({name, "_res"}, result, exp);
    check({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
    check({name, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask
  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
  initial begin
    int n;
    vecs = '{
      '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
      '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
      '{MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34},
      '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34},
      '{MD_MULHU,  32'h8000_0000,  32'd4,         32'd2,         34},
      '{MD_MULH,   32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 34},
      '{MD_MUL,    32'd1000,       32'd1000,      32'd1000000,   34},
      '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34},
      '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34},
      '{MD_DIVU,   32'd100,        32'd7,         32'd14,        34},
      '{MD_REMU,   32'd100,        32'd7,         32'd2,         34},
      '{MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
      '{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34},
      '{MD_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34},
      '{MD_REMU,   32'hFFFF_FFFF,  32'h10,        32'hF,         34},
      '{MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1},
      '{MD_REM,    32'd5,          32'd0,         32'd5,         1},
      '{MD_REMU,   32'd9,          32'd0,         32'd9,         1},
      '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1}
    };
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_result", result, 32'd0);
    for (int i = 0; i < 20; i++)
      run($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    // flush at CALC cycle 10; result must keep the last value (0)
    issue(MD_MUL, 32'd7, 32'd3);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    count_dones(40, n);
    check("flush_no_done", n, 0);
    check("flush_result_kept", result, 32'd0);
    // flush together with start in IDLE: nothing accepted
    flush = 1'b1; op = MD_MUL; a = 32'd4; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    count_dones(40, n);
    check("flush_start_no_done", n, 0);
    run("after_flush", MD_MUL, 32'd7, 32'd3, 32'd21, 34);
    // start pulses while busy and during DONE are ignored
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 op = MD_MUL; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
    end
    check("busy_ign_done_seen", {31'd0, done}, 32'd1);
    check("busy_ign_result", result, 32'd14);
    op = MD_MUL; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_ign_busy", {31'd0, busy}, 32'd0);
    count_dones(45, n);
    check("done_ign_no_done", n, 0);
    check("done_ign_result", result, 32'd14);
    // reset mid-CALC
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    count_dones(40, n);
    check("rst_mid_no_done", n, 0);
    run("after_rst", MD_REMU, 32'd100, 32'd7, 32'd2, 34);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
